fetch_ctrl: RTL and testbench
=============================

# fetch_ctrl

Instruction fetch controller for the single-issue CPU. It owns the program counter, drives the word address into the asynchronous instruction ROM, and captures each returned instruction into a 2-entry prefetch buffer. The buffer feeds decode through a valid/ready handshake. The block also accepts redirects from execute and a halt request, and can optionally fold unconditional jumps in the fetch stage.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- JUMP_OPCODE, 6'b010010, opcode field inst[31:26] identifying an unconditional jump.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- rom_a  out  32  byte address to instruction ROM (ROM indexes a[7:2]).
- rom_inst  in  32  instruction returned combinationally by ROM for rom_a.
- out_valid  out  1  head of prefetch buffer holds a valid instruction.
- out_ready  in  1  decode accepts head this cycle.
- out_inst  out  32  head instruction.
- out_pc  out  32  byte address of head instruction.
- redirect  in  1  execute-stage PC override (taken branch/jump), single-cycle pulse.
- redirect_pc  in  32  new PC, word-aligned (bits [1:0] ignored, forced 0).
- halt  in  1  level; stop issuing new fetches while high.
- halted  out  1  FSM is in HALT.

## Operation
- Registers: pc[31:0], 2-entry FIFO of {pc, inst}, count[1:0], FSM state.
- rom_a = pc, driven directly from the register (no combinational path from inputs).
- FSM states:
  - BOOT: entered on reset, lasts one cycle, no fetch; moves to RUN, or to HALT if halt is high.
  - RUN: normal fetching.
  - HALT: no fetch; returns to RUN on the first cycle halt is low.
- RUN to HALT occurs on any cycle halt is high. That cycle does not fetch.
- fetch = (state==RUN) & ~halt & ~redirect & (count<2 | pop), where pop = out_valid & out_ready.
- On fetch, {pc, rom_inst} is pushed and pc <= pc + 4. The add wraps modulo 2^32, and ROM aliasing every 256 bytes is accepted.
- Redirect has priority over everything except reset, and applies in any state:
  - FIFO is flushed (count <= 0) and pc <= {redirect_pc[31:2], 2'b00}.
  - No push that cycle.
  - A pop in the same cycle counts as completed, but decode must discard that instruction.
  - The FSM state is unchanged.
- Pop and push in the same cycle with count==2 is legal: count stays 2 and ordering is preserved.
- FIFO ordering is strict FIFO. out_inst and out_pc are the head entry, registered.
- Jump folding: see Configuration.

## Timing
- Reset values:
  - pc=RESET_PC, rom_a=RESET_PC, out_valid=0, out_inst=0, out_pc=0, count=0, halted=0, state=BOOT.
- Reset asserted mid-operation: all registers return to their reset values immediately (asynchronous); no partial push survives.
- Fetch latency: an instruction fetched at edge k is visible with out_valid=1 after edge k.
- First instruction after reset release: out_valid rises after the second rising edge (BOOT, then first RUN fetch).
- Redirect sampled at edge k: out_valid=0 after k. rom_a=redirect_pc during cycle k+1, and its instruction is at the head after edge k+1.
- Throughput: one instruction per cycle with out_ready held high.
- Backpressure: with out_ready low and the FIFO full, pc and rom_a hold steady.
- halted is registered and equals (state==HALT).

## Configuration
- FETCH_JUMP_FOLD_EN defined:
  - When fetch occurs and rom_inst[31:26]==JUMP_OPCODE, the jump is not pushed.
  - pc <= {pc[31:28], rom_inst[25:0], 2'b00}.
  - Consecutive jumps fold one per cycle.
- FETCH_JUMP_FOLD_EN undefined:
  - Jumps are pushed like any other instruction and pc <= pc + 4.
  - Execute must issue redirect.

## Test plan
- Reset, then out_ready=1, with ROM word1=addi: out_pc sequence 0x00, 0x04, 0x08 on consecutive cycles; out_inst for 0x04 = 32'h14000309 pattern as loaded.
- out_ready=0 for 5 cycles after reset: count saturates at 2 (entries at 0x00 and 0x04), rom_a stays 0x08, out_valid stays 1, head stays 0x00.
- Redirect to 0x30 while FIFO full and out_ready=0: next cycle out_valid=0; one cycle later out_pc=0x30, followed by 0x34.
- Jump at 0x40 with target field 1:
  - With FETCH_JUMP_FOLD_EN: out_pc goes 0x3C, then 0x04; 0x40 is never presented.
  - Without it: 0x40 is presented and 0x44 follows.
- halt raised at steady state: fetches stop the same cycle, halted=1 the next cycle, and the FIFO drains to out_valid=0. On halt low, fetching resumes at the held pc.
- rst_n pulsed low mid-stream with FIFO full: out_valid=0 and rom_a=RESET_PC immediately, and the sequence restarts from 0x00.

Source files
------------

// File: rtl/fetch_ctrl_if.sv
// ---------------------------------------------------------------------------
// fetch_ctrl_if
//   Bundles the instruction-ROM port, the decode handshake and the
//   execute/halt control lines of the fetch controller.
//
//   Handshake (decode side): an entry moves from fetch to decode on every
//   rising edge where out_valid and out_ready are both high. out_valid,
//   out_inst and out_pc do not depend combinationally on out_ready.
//
//   Signals:
//     rom_a        fetch -> ROM     byte address (ROM indexes a[7:2])
//     rom_inst     ROM   -> fetch   instruction for rom_a (combinational)
//     out_valid    fetch -> decode  head entry valid
//     out_ready    decode-> fetch   decode takes the head this cycle
//     out_inst     fetch -> decode  head instruction
//     out_pc       fetch -> decode  head byte address
//     redirect     exec  -> fetch   single-cycle PC override
//     redirect_pc  exec  -> fetch   new PC (bits [1:0] ignored)
//     halt         ctrl  -> fetch   level, stop fetching while high
//     halted       fetch -> ctrl    controller is parked in HALT
//
//   master: the fetch controller side. slave: ROM/decode/execute side.
// ---------------------------------------------------------------------------
interface fetch_if;
  logic [31:0] rom_a;
  logic [31:0] rom_inst;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        halted;

  modport master (
    output rom_a,
    input  rom_inst,
    output out_valid,
    input  out_ready,
    output out_inst,
    output out_pc,
    input  redirect,
    input  redirect_pc,
    input  halt,
    output halted
  );

  modport slave (
    input  rom_a,
    output rom_inst,
    input  out_valid,
    output out_ready,
    input  out_inst,
    input  out_pc,
    output redirect,
    output redirect_pc,
    output halt,
    input  halted
  );
endinterface

// File: rtl/fetch_ctrl.sv
// ---------------------------------------------------------------------------
// fetch_ctrl
//   Instruction fetch controller. Owns the PC, addresses the asynchronous
//   instruction ROM and captures {pc, inst} pairs into a 2-entry prefetch
//   FIFO whose head feeds decode over a valid/ready handshake. Accepts
//   redirects from execute and a level halt request.
//
//   Optional feature (macro FETCH_JUMP_FOLD_EN): when defined, unconditional
//   jumps (inst[31:26] == JUMP_OPCODE) are folded in fetch: they are not
//   pushed and the PC goes straight to the jump target. When undefined,
//   jumps are pushed like any other instruction.
//
//   Ports:
//     clk          system clock, rising edge
//     rst_n        asynchronous active-low reset
//     bus          fetch_if.master (ROM port, decode handshake, control)
//     o_dbg_state  current FSM state (0=BOOT, 1=RUN, 2=HALT)
//     o_dbg_count  number of valid FIFO entries
// ---------------------------------------------------------------------------
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [5:0]  JUMP_OPCODE = 6'b010010
) (
  input  logic       clk,
  input  logic       rst_n,
  fetch_if.master    bus,
  output logic [1:0] o_dbg_state,
  output logic [1:0] o_dbg_count
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

`ifdef FETCH_JUMP_FOLD_EN
  localparam bit FOLD_EN = 1'b1;
`else
  localparam bit FOLD_EN = 1'b0;
`endif

  state_t      r_state;
  logic        r_halted;
  logic [31:0] r_pc;
  logic [1:0]  r_count;
  logic [31:0] r_head_pc;
  logic [31:0] r_head_inst;
  logic [31:0] r_tail_pc;
  logic [31:0] r_tail_inst;

  logic        w_pop;
  logic        w_fetch;
  logic        w_is_jump;
  logic        w_fold;
  logic        w_push;
  logic [31:0] w_redirect_pc;
  logic [31:0] w_jump_pc;
  logic [31:0] w_seq_pc;

  // A pop during a redirect still completes; decode drops that instruction.
  assign w_pop   = (r_count != 2'd0) & bus.out_ready;

  // Fetch only while running, not halting, not redirecting, and when the
  // FIFO has room either now or because the head leaves this cycle.
  assign w_fetch = (r_state == ST_RUN) & ~bus.halt & ~bus.redirect &
                   ((r_count < 2'd2) | w_pop);

  assign w_is_jump     = (bus.rom_inst[31:26] == JUMP_OPCODE);
  assign w_fold        = FOLD_EN & w_fetch & w_is_jump;
  assign w_push        = w_fetch & ~w_fold;
  assign w_redirect_pc = bus.redirect_pc & ~32'd3;
  assign w_jump_pc     = {r_pc[31:28], bus.rom_inst[25:0], 2'b00};
  assign w_seq_pc      = r_pc + 32'd4;  // wraps modulo 2^32

  // Control FSM. Every state (when not redirected) moves to HALT if halt is
  // high and to RUN otherwise; halted is the registered copy of "in HALT".
  // A redirect freezes the state for that cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_BOOT;
      r_halted <= 1'b0;
    end else if (!bus.redirect) begin
      case (r_state)
        ST_BOOT: begin
          r_state  <= bus.halt ? ST_HALT : ST_RUN;
          r_halted <= bus.halt;
        end
        ST_RUN: begin
          r_state  <= bus.halt ? ST_HALT : ST_RUN;
          r_halted <= bus.halt;
        end
        ST_HALT: begin
          r_state  <= bus.halt ? ST_HALT : ST_RUN;
          r_halted <= bus.halt;
        end
        default: begin
          r_state  <= ST_BOOT;
          r_halted <= 1'b0;
        end
      endcase
    end
  end

  // Program counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= RESET_PC;
    end else if (bus.redirect) begin
      r_pc <= w_redirect_pc;
    end else if (w_fold) begin
      r_pc <= w_jump_pc;
    end else if (w_fetch) begin
      r_pc <= w_seq_pc;
    end
  end

  // Prefetch FIFO: head registers drive decode directly, tail holds the
  // second entry. Entries only move tail->head, so ordering is preserved.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count     <= 2'd0;
      r_head_pc   <= 32'd0;
      r_head_inst <= 32'd0;
      r_tail_pc   <= 32'd0;
      r_tail_inst <= 32'd0;
    end else if (bus.redirect) begin
      r_count <= 2'd0;
    end else begin
      case (r_count)
        2'd0: begin
          if (w_push) begin
            r_head_pc   <= r_pc;
            r_head_inst <= bus.rom_inst;
            r_count     <= 2'd1;
          end
        end
        2'd1: begin
          case ({w_pop, w_push})
            2'b11: begin
              r_head_pc   <= r_pc;
              r_head_inst <= bus.rom_inst;
            end
            2'b10: r_count <= 2'd0;
            2'b01: begin
              r_tail_pc   <= r_pc;
              r_tail_inst <= bus.rom_inst;
              r_count     <= 2'd2;
            end
            default: r_count <= 2'd1;
          endcase
        end
        2'd2: begin
          // A push at count 2 is only possible together with a pop.
          if (w_pop) begin
            r_head_pc   <= r_tail_pc;
            r_head_inst <= r_tail_inst;
            if (w_push) begin
              r_tail_pc   <= r_pc;
              r_tail_inst <= bus.rom_inst;
            end else begin
              r_count <= 2'd1;
            end
          end
        end
        default: r_count <= 2'd0;
      endcase
    end
  end

  assign bus.rom_a     = r_pc;
  assign bus.out_valid = (r_count != 2'd0);
  assign bus.out_inst  = r_head_inst;
  assign bus.out_pc    = r_head_pc;
  assign bus.halted    = r_halted;
  assign o_dbg_state   = r_state;
  assign o_dbg_count   = r_count;

endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;

`ifdef FETCH_JUMP_FOLD_EN
  localparam bit FOLD = 1'b1;
`else
  localparam bit FOLD = 1'b0;
`endif
  localparam logic [5:0] JOP = 6'b010010;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fetch_if bus();
  logic [1:0] dbg_state;
  logic [1:0] dbg_count;

  fetch_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .o_dbg_state (dbg_state),
    .o_dbg_count (dbg_count)
  );

  // Asynchronous ROM, 64 words, aliasing every 256 bytes.
  logic [31:0] rom [64];
  assign bus.rom_inst = rom[bus.rom_a[7:2]];

  // ---------------- behavioural model ----------------
  logic [31:0] m_pc;
  logic [63:0] exp_q[$];   // {pc, inst} in presentation order
  bit          m_run;      // controller is allowed to fetch
  bit          m_halt;     // controller is parked

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0;
    exp_q.delete();
    m_run = 1'b0;
    m_halt = 1'b0;
  endtask

  task automatic model_step(input bit rd, input logic [31:0] rdpc, input bit hlt, input bit rdy);
    int n;
    bit pop;
    bit fetch;
    logic [31:0] inst;
    n = exp_q.size();
    pop = (n != 0) && rdy;
    if (pop) void'(exp_q.pop_front());
    if (rd) begin
      exp_q.delete();
      m_pc = rdpc & ~32'd3;
    end else begin
      fetch = m_run && !hlt && (n < 2 || pop);
      m_run = !hlt;
      m_halt = hlt;
      if (fetch) begin
        inst = rom[m_pc[7:2]];
        if (FOLD && inst[31:26] == JOP) begin
          m_pc = {m_pc[31:28], inst[25:0], 2'b00};
        end else begin
          exp_q.push_back({m_pc, inst});
          m_pc = m_pc + 32'd4;
        end
      end
    end
  endtask

  // Per-cycle comparison of every meaningful output against the model.
  task automatic compare_model();
    logic [63:0] head;
    chk("rom_a", bus.rom_a, m_pc);
    chk("out_valid", {31'd0, bus.out_valid}, {31'd0, exp_q.size() != 0});
    chk("halted", {31'd0, bus.halted}, {31'd0, m_halt});
    chk("count", {30'd0, dbg_count}, exp_q.size());
    if (exp_q.size() != 0) begin
      head = exp_q[0];
      chk("out_pc", bus.out_pc, head[63:32]);
      chk("out_inst", bus.out_inst, head[31:0]);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called at a falling edge; returns at the next falling edge after checking.
  task automatic tick(input bit rd, input logic [31:0] rdpc, input bit hlt, input bit rdy);
    bus.redirect    = rd;
    bus.redirect_pc = rdpc;
    bus.halt        = hlt;
    bus.out_ready   = rdy;
    #1;
    model_step(rd, rdpc, hlt, rdy);
    @(posedge clk);
    @(negedge clk);
    compare_model();
  endtask

  task automatic do_reset();
    bus.redirect  = 1'b0;
    bus.halt      = 1'b0;
    bus.out_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_rom_a", bus.rom_a, 32'h0000_0000);
    chk("rst_halted", {31'd0, bus.halted}, 32'd0);
    chk("rst_out_pc", bus.out_pc, 32'd0);
    chk("rst_out_inst", bus.out_inst, 32'd0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    compare_model();
  endtask

  logic [31:0] seen_q[$];
  logic [31:0] exp_after_1;
  logic [31:0] exp_after_2;

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] w;
    bit h;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'd0;
    bus.halt        = 1'b0;
    bus.out_ready   = 1'b0;
    for (int i = 0; i < 64; i++) begin
      w = $urandom;
      if (w[31:26] == JOP) w[31:26] = 6'b000101;
      rom[i] = w;
    end
    rom[1]  = 32'h1400_0309;
    rom[16] = 32'h4800_0001;  // jump at 0x40, target field 1

    @(negedge clk);
    do_reset();

    // Startup stream with decode always ready.
    tick(0, 0, 0, 1);
    chk("boot_no_valid", {31'd0, bus.out_valid}, 32'd0);
    tick(0, 0, 0, 1);
    chk("first_pc", bus.out_pc, 32'h00);
    tick(0, 0, 0, 1);
    chk("second_pc", bus.out_pc, 32'h04);
    chk("second_inst", bus.out_inst, 32'h1400_0309);
    tick(0, 0, 0, 1);
    chk("third_pc", bus.out_pc, 32'h08);

    // Halt at steady state.
    do_reset();
    tick(0, 0, 0, 1);
    tick(0, 0, 0, 1);
    tick(0, 0, 0, 1);
    tick(0, 0, 1, 1);
    chk("halt_flag", {31'd0, bus.halted}, 32'd1);
    chk("halt_drained", {31'd0, bus.out_valid}, 32'd0);
    chk("halt_rom_a", bus.rom_a, 32'h08);
    tick(0, 0, 1, 1);
    tick(0, 0, 1, 1);
    chk("halt_hold_rom_a", bus.rom_a, 32'h08);
    tick(0, 0, 0, 1);
    chk("unhalt_flag", {31'd0, bus.halted}, 32'd0);
    tick(0, 0, 0, 1);
    chk("resume_pc", bus.out_pc, 32'h08);

    // Backpressure: FIFO saturates at two entries.
    do_reset();
    for (int i = 0; i < 5; i++) tick(0, 0, 0, 0);
    chk("bp_rom_a", bus.rom_a, 32'h08);
    chk("bp_count", {30'd0, dbg_count}, 32'd2);
    chk("bp_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("bp_head", bus.out_pc, 32'h00);

    // Redirect while full and stalled (low bits must be ignored).
    tick(1, 32'h33, 0, 0);
    chk("rd_flush", {31'd0, bus.out_valid}, 32'd0);
    chk("rd_rom_a", bus.rom_a, 32'h30);
    tick(0, 0, 0, 1);
    chk("rd_head", bus.out_pc, 32'h30);
    tick(0, 0, 0, 1);
    chk("rd_next", bus.out_pc, 32'h34);

    // Jump at 0x40 entered from 0x3C.
    exp_after_1 = FOLD ? 32'h04 : 32'h40;
    exp_after_2 = FOLD ? 32'h08 : 32'h44;
    tick(1, 32'h3C, 0, 1);
    seen_q.delete();
    for (int i = 0; i < 10 && seen_q.size() < 3; i++) begin
      tick(0, 0, 0, 1);
      if (bus.out_valid) seen_q.push_back(bus.out_pc);
    end
    if (seen_q.size() < 3) begin
      checks++;
      errors++;
      $display("FAIL jump_budget: got %0d entries expected 3", seen_q.size());
    end else begin
      chk("jump_pre", seen_q[0], 32'h3C);
      chk("jump_after1", seen_q[1], exp_after_1);
      chk("jump_after2", seen_q[2], exp_after_2);
    end

    // PC wrap at the top of the address space.
    tick(1, 32'hFFFF_FFFE, 0, 1);
    chk("wrap_rom_a", bus.rom_a, 32'hFFFF_FFFC);
    tick(0, 0, 0, 1);
    chk("wrap_pc", bus.rom_a, 32'h0000_0000);
    chk("wrap_head", bus.out_pc, 32'hFFFF_FFFC);

    // Reset mid-stream with a full FIFO.
    for (int i = 0; i < 4; i++) tick(0, 0, 0, 0);
    chk("full_before_reset", {30'd0, dbg_count}, 32'd2);
    do_reset();
    tick(0, 0, 0, 1);
    tick(0, 0, 0, 1);
    chk("restart_pc", bus.out_pc, 32'h00);

    // Randomized traffic against the model.
    h = 1'b0;
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 9) == 0) h = ~h;
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        tick($urandom_range(0, 15) == 0,
             ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 255)),
             h,
             $urandom_range(0, 3) != 0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
